// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_seq_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // ALU operation selects
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    // Condition codes
    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1,
        CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5,
        VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9,
        GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD,
        AL = 4'hE, NV = 4'hF
    } cond_e;

    // Bit positions inside a {N,Z,C,V} flags nibble
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_cmd_sequencer_cond_eval.sv
// Combinational condition-code evaluator over a {N,Z,C,V} flags nibble.
module cond_eval
    import alu_seq_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       true
);

    logic n, z, c, v;

    // Decode the condition code against the supplied flags
    always_comb begin
        n    = flags[FLAG_N];
        z    = flags[FLAG_Z];
        c    = flags[FLAG_C];
        v    = flags[FLAG_V];
        true = 1'b0;
        case (cond_e'(cond))
            EQ: true = z;
            NE: true = ~z;
            CS: true = c;
            CC: true = ~c;
            MI: true = n;
            PL: true = ~n;
            VS: true = v;
            VC: true = ~v;
            HI: true = c & ~z;
            LS: true = ~c | z;
            GE: true = (n == v);
            LT: true = (n != v);
            GT: true = ~z & (n == v);
            LE: true = z | (n != v);
            AL: true = 1'b1;
            NV: true = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-side initiator for the 4-bit ALU: accepts a command, drives the
// ALU from registers, captures result/flags, maintains the architectural
// flags register and returns a response with the evaluated condition.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [1:0]       cmd_sel,
    input  logic             cmd_setf,
    input  logic [3:0]       cmd_cond,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_v,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_cond_true,
    output logic [3:0]       flags
);

    state_e           state_q;
    logic             cmd_ready_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [1:0]       alu_sel_q;
    logic             setf_q;
    logic [3:0]       cond_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic [3:0]       rsp_flags_q;
    logic             rsp_cond_q;
    logic [3:0]       flags_q;

    logic [3:0]       alu_flags;
    logic [3:0]       eval_flags;
    logic             cond_true;

    // Condition sees the flags as they will be after this command
    always_comb begin
        alu_flags  = {alu_n, alu_z, alu_c, alu_v};
        eval_flags = setf_q ? alu_flags : flags_q;
    end

    cond_eval u_cond_eval (
        .flags (eval_flags),
        .cond  (cond_q),
        .true  (cond_true)
    );

    // Sequencer FSM with registered handshake and datapath outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            setf_q       <= 1'b0;
            cond_q       <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_cond_q   <= 1'b0;
            flags_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a_q     <= cmd_a;
                        alu_b_q     <= cmd_b;
                        alu_sel_q   <= cmd_sel;
                        setf_q      <= cmd_setf;
                        cond_q      <= cmd_cond;
                        cmd_ready_q <= 1'b0;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result_q <= alu_result;
                    rsp_flags_q  <= alu_flags;
                    if (setf_q) begin
                        flags_q <= alu_flags;
                    end
                    rsp_cond_q   <= cond_true;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_sel       = alu_sel_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_flags     = rsp_flags_q;
    assign rsp_cond_true = rsp_cond_q;
    assign flags         = flags_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard testbench for alu_cmd_sequencer with a behavioural ALU beside it.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a, cmd_b;
    logic [1:0] cmd_sel;
    logic       cmd_setf;
    logic [3:0] cmd_cond;
    logic [3:0] alu_a, alu_b;
    logic [1:0] alu_sel;
    logic [3:0] alu_result;
    logic       alu_n, alu_z, alu_c, alu_v;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic [3:0] rsp_flags;
    logic       rsp_cond_true;
    logic [3:0] flags;

    int vectors   = 0;
    int miscomp   = 0;
    int cyc       = 0;
    int rdy_mode  = 2;   // 0 random, 1 force low, 2 force high
    logic [3:0] model_flags = 4'h0;

    typedef struct {
        logic [3:0] res;
        logic [3:0] rflags;
        logic       cond;
        logic [3:0] flags;
        int         acc;
    } exp_t;

    exp_t sb_q[$];

    alu_cmd_sequencer #(.WIDTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .cmd_sel       (cmd_sel),
        .cmd_setf      (cmd_setf),
        .cmd_cond      (cmd_cond),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_sel       (alu_sel),
        .alu_result    (alu_result),
        .alu_n         (alu_n),
        .alu_z         (alu_z),
        .alu_c         (alu_c),
        .alu_v         (alu_v),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_flags     (rsp_flags),
        .rsp_cond_true (rsp_cond_true),
        .flags         (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Combinational 4-bit ALU (C is borrow on SUB, C=V=0 on AND/OR)
    logic [4:0] alu_wide;
    always_comb begin
        alu_wide = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (alu_sel)
            OP_ADD: begin
                alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
                alu_c    = alu_wide[4];
                alu_v    = (alu_a[3] == alu_b[3]) && (alu_wide[3] != alu_a[3]);
            end
            OP_SUB: begin
                alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
                alu_c    = alu_wide[4];
                alu_v    = (alu_a[3] != alu_b[3]) && (alu_wide[3] != alu_a[3]);
            end
            OP_AND: alu_wide = {1'b0, alu_a & alu_b};
            OP_OR:  alu_wide = {1'b0, alu_a | alu_b};
        endcase
        alu_result = alu_wide[3:0];
        alu_n      = alu_wide[3];
        alu_z      = (alu_wide[3:0] == 4'h0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscomp++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sval(input int x);
        return (x >= 8) ? x - 16 : x;
    endfunction

    function automatic logic cond_holds(input logic [3:0] f, input logic [3:0] code);
        bit n = f[3], z = f[2], c = f[1], v = f[0];
        case (code)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Reference: arithmetic on integers, signed overflow by range check
    task automatic model_cmd(input int a, input int b, input int sel, input bit setf,
                             input logic [3:0] code, input int acc, output exp_t e);
        int r, sr;
        bit c, v;
        c = 0; v = 0; r = 0;
        case (sel)
            0: begin r = a + b; c = (r > 15); sr = sval(a) + sval(b); v = (sr < -8) || (sr > 7); end
            1: begin r = a - b; c = (a < b);  sr = sval(a) - sval(b); v = (sr < -8) || (sr > 7); end
            2: r = a & b;
            default: r = a | b;
        endcase
        r = r & 15;
        e.res    = 4'(r);
        e.rflags = {r >= 8, r == 0, c, v};
        if (setf) model_flags = e.rflags;
        e.flags  = model_flags;
        e.cond   = cond_holds(model_flags, code);
        e.acc    = acc;
    endtask

    task automatic send(input int a, input int b, input int sel, input bit setf,
                        input int code, input bit expect_rsp);
        int   w;
        exp_t e;
        @(negedge clk);
        cmd_a = 4'(a); cmd_b = 4'(b); cmd_sel = 2'(sel);
        cmd_setf = setf; cmd_cond = 4'(code); cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        model_cmd(a, b, sel, setf, 4'(code), cyc + 1, e);
        if (expect_rsp) sb_q.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_sel = 2'($urandom);
    endtask

    task automatic drain();
        int w = 0;
        while ((sb_q.size() != 0 || !cmd_ready) && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("drain_pending", 32'(sb_q.size()), 32'd0);
    endtask

    // Response-ready driver
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rdy_mode == 0)      rsp_ready = ($urandom_range(0, 3) != 0);
            else if (rdy_mode == 1) rsp_ready = 1'b0;
            else                    rsp_ready = 1'b1;
        end
    end

    // Monitor: pops on each new response, then checks it stays stable
    exp_t cur;
    bit   have_cur = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_cur = 0;
            end else if (rsp_valid && !have_cur) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    cur = sb_q.pop_front();
                    have_cur = 1;
                    chk("rsp_result", 32'(rsp_result), 32'(cur.res));
                    chk("rsp_flags", 32'(rsp_flags), 32'(cur.rflags));
                    chk("rsp_cond_true", 32'(rsp_cond_true), 32'(cur.cond));
                    chk("flags_reg", 32'(flags), 32'(cur.flags));
                    chk("latency", 32'(cyc), 32'(cur.acc + 1));
                    chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
                end
            end else if (rsp_valid && have_cur) begin
                chk("hold_result", 32'(rsp_result), 32'(cur.res));
                chk("hold_flags", 32'(rsp_flags), 32'(cur.rflags));
                chk("hold_cond", 32'(rsp_cond_true), 32'(cur.cond));
                chk("hold_flags_reg", 32'(flags), 32'(cur.flags));
                chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            end else begin
                have_cur = 0;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0;
        cmd_setf = 1'b0; cmd_cond = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_ops", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        chk("rst_rsp_data", 32'({rsp_result, rsp_flags, rsp_cond_true}), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        rst_n = 1'b1;

        // Directed sequence
        send(3, 4, 0, 1, 4'hE, 1);
        drain();
        chk("flags_add37", 32'(flags), 32'h0);
        send(5, 5, 1, 1, 4'h0, 1);
        send(2, 1, 2, 0, 4'h1, 1);
        drain();
        chk("flags_sub55", 32'(flags), 32'h4);
        send(7, 1, 0, 1, 4'hA, 1);
        send(7, 1, 0, 1, 4'hB, 1);
        drain();
        chk("flags_add71", 32'(flags), 32'h9);
        send(15, 1, 0, 1, 4'h2, 1);
        send(12, 3, 2, 0, 4'h0, 1);
        drain();
        chk("flags_and_nosetf", 32'(flags), 32'h6);
        chk("rspflags_and", 32'(rsp_flags), 32'h4);

        // Backpressure: response held while a second command waits
        rdy_mode = 1;
        send(2, 3, 0, 1, 4'h4, 1);
        fork
            send(9, 9, 1, 1, 4'h0, 1);
            begin
                repeat (7) @(negedge clk);
                rdy_mode = 2;
            end
        join
        drain();

        // Reset pulse while the command is in EXEC
        send(9, 9, 1, 1, 4'hE, 0);
        rst_n = 1'b0;
        model_flags = 4'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
            chk("rst_mid_flags", 32'(flags), 32'd0);
            chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
        end
        send(6, 2, 1, 1, 4'hC, 1);
        drain();

        // Randomised traffic with random backpressure
        rdy_mode = 0;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), $urandom_range(0, 15), 1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
        $finish;
    end

endmodule
